// File: rtl/reg_file_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | reg_file_pkg : shared defaults, types and address helpers for reg_file_sb |
// | Optional feature macro: REG_FILE_BYPASS_EN    Revision: 1.0               |
// +---------------------------------------------------------------------------+
package reg_file_pkg;

  localparam int RF_M  = 32;
  localparam int RF_N  = 8;
  localparam int RF_NR = 2;
  localparam int RF_A  = $clog2(RF_M);

  typedef logic [RF_A-1:0] reg_addr_t;
  typedef logic [RF_N-1:0] reg_data_t;

  function automatic logic is_zero_reg(input logic [31:0] addr);
    return addr == 32'd0;
  endfunction

  // Real register: not the virtual r0 and inside a non-power-of-2 file.
  function automatic logic reg_addr_ok(input logic [31:0] addr, input int unsigned m);
    return !is_zero_reg(addr) && (addr < m);
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | reg_scoreboard : per-register outstanding-load busy bits and hazard flag  |
// | Optional feature macro: REG_FILE_BYPASS_EN (used by top)  Revision: 1.0   |
// +---------------------------------------------------------------------------+
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int M  = RF_M,
  parameter int NR = RF_NR,
  parameter int A  = $clog2(M)
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic [NR-1:0][A-1:0]  i_rd_addr,
  input  logic                  i_wa_en,
  input  logic [A-1:0]          i_wa_addr,
  input  logic                  i_ld_issue,
  input  logic [A-1:0]          i_ld_addr,
  input  logic                  i_lw_xfer,
  input  logic [A-1:0]          i_lw_addr,
  output logic [NR-1:0]         o_rd_busy,
  output logic                  o_hazard_err
);

  logic [M-1:0] r_busy;
  logic [M-1:0] w_busy_nxt;
  logic         r_hazard_err;
  logic         w_wa_ok;
  logic         w_ld_ok;
  logic         w_lw_ok;
  logic         w_hazard;

  assign w_wa_ok = i_wa_en    && reg_addr_ok(32'(i_wa_addr), M);
  assign w_ld_ok = i_ld_issue && reg_addr_ok(32'(i_ld_addr), M);
  assign w_lw_ok = i_lw_xfer  && reg_addr_ok(32'(i_lw_addr), M);

  // Clear first, set last: a newer issue to the same register stays outstanding.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_lw_ok) w_busy_nxt[i_lw_addr] = 1'b0;
    if (w_ld_ok) w_busy_nxt[i_ld_addr] = 1'b1;
  end

  assign w_hazard = (w_wa_ok &&  r_busy[i_wa_addr])
                 || (w_lw_ok && !r_busy[i_lw_addr])
                 || (w_ld_ok &&  r_busy[i_ld_addr]);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_busy       <= '0;
      r_hazard_err <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_hazard) r_hazard_err <= 1'b1;
    end
  end

  for (genvar g = 0; g < NR; g++) begin : g_rd_busy
    assign o_rd_busy[g] = reg_addr_ok(32'(i_rd_addr[g]), M) && r_busy[i_rd_addr[g]];
  end

  assign o_hazard_err = r_hazard_err;

endmodule
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | reg_file_sb : multi-port register file with handshaked load write-back    |
// | Optional feature macro: REG_FILE_BYPASS_EN (write-to-read forwarding)     |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter  int M  = RF_M,
  parameter  int N  = RF_N,
  parameter  int NR = RF_NR,
  localparam int A  = $clog2(M)
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic [NR-1:0][A-1:0]  rd_addr,
  output logic [NR-1:0][N-1:0]  rd_data,
  output logic [NR-1:0]         rd_busy,
  input  logic                  wa_en,
  input  logic [A-1:0]          wa_addr,
  input  logic [N-1:0]          wa_data,
  input  logic                  ld_issue,
  input  logic [A-1:0]          ld_addr,
  input  logic                  lw_valid,
  output logic                  lw_ready,
  input  logic [A-1:0]          lw_addr,
  input  logic [N-1:0]          lw_data,
  output logic                  hazard_err
);

  logic [N-1:0]  r_regs [M];
  logic          w_wa_we;
  logic          w_lw_xfer;
  logic          w_lw_we;
  logic [NR-1:0] w_sb_busy;

  // The ALU port always wins; a blocked write-back simply waits upstream.
  assign lw_ready  = !(wa_en && !is_zero_reg(32'(wa_addr)));
  assign w_wa_we   = wa_en && reg_addr_ok(32'(wa_addr), M);
  assign w_lw_xfer = lw_valid && lw_ready;
  assign w_lw_we   = w_lw_xfer && reg_addr_ok(32'(lw_addr), M);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < M; i++) r_regs[i] <= '0;
    end else begin
      if (w_wa_we) r_regs[wa_addr] <= wa_data;
      if (w_lw_we) r_regs[lw_addr] <= lw_data;
    end
  end

  reg_scoreboard #(
    .M  (M),
    .NR (NR),
    .A  (A)
  ) u_scoreboard (
    .clk          (clk),
    .n_reset      (n_reset),
    .i_rd_addr    (rd_addr),
    .i_wa_en      (wa_en),
    .i_wa_addr    (wa_addr),
    .i_ld_issue   (ld_issue),
    .i_ld_addr    (ld_addr),
    .i_lw_xfer    (w_lw_xfer),
    .i_lw_addr    (lw_addr),
    .o_rd_busy    (w_sb_busy),
    .o_hazard_err (hazard_err)
  );

  for (genvar g = 0; g < NR; g++) begin : g_rd_port
    logic [N-1:0] w_data;
    logic         w_busy;

    always_comb begin
      w_data = reg_addr_ok(32'(rd_addr[g]), M) ? r_regs[rd_addr[g]] : '0;
      w_busy = w_sb_busy[g];
`ifdef REG_FILE_BYPASS_EN
      if (w_wa_we && (wa_addr == rd_addr[g])) begin
        w_data = wa_data;
      end else if (w_lw_we && (lw_addr == rd_addr[g])) begin
        w_data = lw_data;
        if (!(ld_issue && (ld_addr == lw_addr))) w_busy = 1'b0;
      end
`endif
    end

    assign rd_data[g] = w_data;
    assign rd_busy[g] = w_busy;
  end

endmodule
`default_nettype wire

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised multi-read-port register file with a second, handshaked write-back port for late (load) results. A per-register busy scoreboard tracks outstanding loads. Read ports report pending-load hazards so the pico-MIPS decode/stall logic can stall on them. Register 0 is virtual and always reads 0.

Parameters:
M, 32, number of architectural registers including virtual r0; A = $clog2(M)
N, 8, data width in bits
NR, 2, number of independent combinational read ports (1..4)

Ports:
clk  input  1  clock, rising edge
n_reset  input  1  asynchronous active-low reset
rd_addr  input  NR x A  read addresses, one per port
rd_data  output  NR x N  read data, one per port
rd_busy  output  NR  per port: addressed register has an outstanding load
wa_en  input  1  ALU write enable
wa_addr  input  A  ALU write address
wa_data  input  N  ALU write data
ld_issue  input  1  load issued; marks ld_addr busy
ld_addr  input  A  destination of the issued load
lw_valid  input  1  load write-back valid
lw_ready  output  1  load write-back accepted this cycle
lw_addr  input  A  load write-back address
lw_data  input  N  load write-back data
hazard_err  output  1  sticky protocol-violation flag

Behaviour:
- Reset (async, n_reset low): all registers 1..M-1 = 0, all busy bits = 0, hazard_err = 0. Reset mid-operation discards outstanding loads.
- Reads: combinational. rd_data[i] = 0 and rd_busy[i] = 0 when rd_addr[i] == 0. Otherwise rd_data[i] = stored value and rd_busy[i] = busy bit, both from the pre-edge state.
- ALU write: on the clk edge with wa_en && wa_addr != 0, the register is written with wa_data. Zero latency to the next-cycle read.
- Load write-back handshake: lw_ready = !(wa_en && wa_addr != 0), combinational. The ALU port has strict priority.
  - Transfer occurs when lw_valid && lw_ready. The register is written with lw_data (if lw_addr != 0) and its busy bit is cleared.
  - lw_valid held without ready: the source must hold addr/data stable until transfer. The block keeps no buffer.
- Scoreboard: ld_issue && ld_addr != 0 sets busy[ld_addr] on the edge.
  - Issue and accepted write-back to the same address in the same cycle: set wins, busy remains 1 (a newer load is outstanding). The write-back data is still written.
  - Issue and write-back to different addresses: both take effect.
- Same-address ALU write and load write-back in one cycle cannot both transfer, because lw_ready = 0.
- hazard_err is set (sticky until reset) on the edge following any of:
  - an ALU write to a register whose busy bit is 1 (WAW; the write is still performed, busy unchanged);
  - an accepted load write-back to a register whose busy bit is 0;
  - ld_issue to a register already busy.
- Writes, issues and write-backs to address 0 are ignored and never raise hazard_err.
- Addresses >= M (non-power-of-2 M): reads return 0 with busy 0; writes and issues are ignored.

Optional Feature:
Macro REG_FILE_BYPASS_EN.
- Defined: write-to-read forwarding. When a read address matches a write occurring this cycle, rd_data returns the new data combinationally.
  - Priority: ALU write data, then accepted load write-back data.
  - A matching accepted load write-back also forces rd_busy to 0 for that port, unless ld_issue targets the same address this cycle.
- Not defined: reads return the pre-edge register contents and busy state only. The new value is visible on the cycle after the edge.

Decomposition:
- Package reg_file_pkg: localparams for defaults (RF_M, RF_N, RF_NR); typedefs reg_addr_t (logic [A-1:0]) and reg_data_t (logic [N-1:0]); a function is_zero_reg.
- One sub-module, reg_scoreboard, holding busy bits 1..M-1, set/clear/priority logic, busy lookup per read port and hazard_err generation. reg_file_sb instantiates it beside the storage array.

Test Plan:
- Reset, then read all ports at addresses 0, 5, 31 -> rd_data = 0 and rd_busy = 0 on every port; hazard_err = 0.
- wa_en, wa_addr = 7, wa_data = 8'hA5; next cycle read 7 on both ports -> 8'hA5. Write to r0 with 8'hFF -> r0 still reads 0.
- ld_issue, ld_addr = 3; next cycle rd_busy = 1 for addr 3. Then lw_valid, addr 3, data 8'h3C with wa_en = 0 -> lw_ready = 1; next cycle r3 = 8'h3C and busy = 0.
- Busy r4; drive lw_valid (r4, 8'h11) and wa_en (r9, 8'h22) together -> lw_ready = 0, r9 = 8'h22. Hold lw_valid, drop wa_en -> transfer, r4 = 8'h11, busy cleared, hazard_err = 0.
- Protocol violations:
  - ALU write to busy r4 -> hazard_err = 1 and stays 1.
  - Write-back to non-busy r6 -> hazard_err = 1.
  - Async n_reset low mid-transfer -> all state 0 immediately.
- With REG_FILE_BYPASS_EN: wa_en r2 = 8'h5A while rd_addr[0] = 2 -> same-cycle rd_data[0] = 8'h5A. Without the macro -> old value, 8'h5A on the next cycle.
